// File: rtl/ram_t0_arbiter_pkg.sv
// ============================================================================
// Module      : ram_t0_arbiter_pkg
// Description : Shared types and constants for the two-requester RAM arbiter
//               (FSM state enum, grant enum, default burst length).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package ram_t0_arbiter_pkg;

    // Arbiter FSM: idle/arbitrating, write burst, read burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // Identity of the requester that owned the most recent burst
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    localparam int c_max_burst_default = 16;

endpackage : ram_t0_arbiter_pkg

`default_nettype wire

// File: rtl/ram_t0_arbiter.sv
// ============================================================================
// Module      : ram_t0_arbiter
// Description : Arbitrates one write and one read requester onto a single-port
//               RAM with 1-cycle read latency. A requester keeps the port for
//               up to MAX_BURST consecutive beats; the burst ends early when
//               its valid drops. Config macro RAM_ARB_RR_EN: round-robin on
//               contention in IDLE; undefined: write has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ram_t0_arbiter
    import ram_t0_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int MAX_BURST  = c_max_burst_default
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    localparam logic [7:0] C_MAX = 8'(MAX_BURST);

    state_t     state_q,      state_d;
    logic [7:0] beat_q,       beat_d;
    grant_t     last_grant_q, last_grant_d;
    logic       rsp_valid_q,  rsp_valid_d;

    logic       w_both_pick_wr;
    logic       w_do_wr;
    logic       w_do_rd;
    logic [7:0] w_next_beat;

    // Contention policy in IDLE: alternate owners, or write always first
`ifdef RAM_ARB_RR_EN
    assign w_both_pick_wr = (last_grant_q == GNT_RD);
`else
    assign w_both_pick_wr = 1'b1;
`endif

    // Read data comes straight from the RAM; valid is masked during reset so a
    // read accepted just before reset never reports a response
    assign rsp_data  = ram_douta;
    assign rsp_valid = rsp_valid_q & ~rsta;

    // Arbitration, burst tracking and RAM port drive
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        wr_ready     = 1'b0;
        rd_ready     = 1'b0;
        ram_ena      = 1'b0;
        ram_wea      = 1'b0;
        ram_addra    = wr_addr;
        ram_dina     = wr_data;
        w_do_wr      = 1'b0;
        w_do_rd      = 1'b0;
        w_next_beat  = beat_q + 8'd1;

        case (state_q)
            IDLE: begin
                w_next_beat = 8'd1;
                w_do_wr     = wr_valid & (~rd_valid | w_both_pick_wr);
                w_do_rd     = rd_valid & ~w_do_wr;
            end
            WR: begin
                w_do_wr = wr_valid;
                if (!wr_valid) begin
                    state_d      = IDLE;
                    beat_d       = 8'd0;
                    last_grant_d = GNT_WR;
                end
            end
            RD: begin
                w_do_rd = rd_valid;
                if (!rd_valid) begin
                    state_d      = IDLE;
                    beat_d       = 8'd0;
                    last_grant_d = GNT_RD;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 8'd0;
            end
        endcase

        if (w_do_wr) begin
            wr_ready  = 1'b1;
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = wr_addr;
        end else if (w_do_rd) begin
            rd_ready    = 1'b1;
            ram_ena     = 1'b1;
            ram_addra   = rd_addr;
            rsp_valid_d = 1'b1;
        end

        // An accept either continues the burst or, at the limit, returns to
        // IDLE so the other requester gets a chance to arbitrate
        if (w_do_wr || w_do_rd) begin
            if (w_next_beat == C_MAX) begin
                state_d      = IDLE;
                beat_d       = 8'd0;
                last_grant_d = w_do_wr ? GNT_WR : GNT_RD;
            end else begin
                state_d = w_do_wr ? WR : RD;
                beat_d  = w_next_beat;
            end
        end

        // Nothing is issued or accepted while reset is held
        if (rsta) begin
            wr_ready    = 1'b0;
            rd_ready    = 1'b0;
            ram_ena     = 1'b0;
            ram_wea     = 1'b0;
            rsp_valid_d = 1'b0;
        end
    end

    // State, burst counter, last owner and response-valid registers
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q      <= IDLE;
            beat_q       <= 8'd0;
            last_grant_q <= GNT_RD;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

endmodule : ram_t0_arbiter

`default_nettype wire

// File: tb/tb_ram_t0_arbiter.sv
// ============================================================================
// Module      : tb_ram_t0_arbiter
// Description : Directed self-checking bench for ram_t0_arbiter. Instance A
//               uses MAX_BURST=16, instance B uses MAX_BURST=4; each drives a
//               behavioural single-port RAM with 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_t0_arbiter;
    import ram_t0_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A (MAX_BURST = 16) ----------------
    logic       rst_a, wv_a, wrdy_a, rv_a, rrdy_a, rspv_a, ena_a, wea_a;
    logic [7:0] wa_a, wd_a, ra_a, rspd_a, addr_a, din_a, dout_a;
    logic [7:0] mem_a [0:255];

    ram_t0_arbiter #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MAX_BURST(16)) u_a (
        .clka(clk), .rsta(rst_a),
        .wr_valid(wv_a), .wr_ready(wrdy_a), .wr_addr(wa_a), .wr_data(wd_a),
        .rd_valid(rv_a), .rd_ready(rrdy_a), .rd_addr(ra_a),
        .rsp_valid(rspv_a), .rsp_data(rspd_a),
        .ram_ena(ena_a), .ram_wea(wea_a), .ram_addra(addr_a), .ram_dina(din_a),
        .ram_douta(dout_a)
    );

    always @(posedge clk) begin
        if (ena_a) begin
            if (wea_a) mem_a[addr_a] <= din_a;
            else       dout_a        <= mem_a[addr_a];
        end
    end

    // ---------------- instance B (MAX_BURST = 4) ----------------
    logic       rst_b, wv_b, wrdy_b, rv_b, rrdy_b, rspv_b, ena_b, wea_b;
    logic [7:0] wa_b, wd_b, ra_b, rspd_b, addr_b, din_b, dout_b;
    logic [7:0] mem_b [0:255];

    ram_t0_arbiter #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MAX_BURST(4)) u_b (
        .clka(clk), .rsta(rst_b),
        .wr_valid(wv_b), .wr_ready(wrdy_b), .wr_addr(wa_b), .wr_data(wd_b),
        .rd_valid(rv_b), .rd_ready(rrdy_b), .rd_addr(ra_b),
        .rsp_valid(rspv_b), .rsp_data(rspd_b),
        .ram_ena(ena_b), .ram_wea(wea_b), .ram_addra(addr_b), .ram_dina(din_b),
        .ram_douta(dout_b)
    );

    always @(posedge clk) begin
        if (ena_b) begin
            if (wea_b) mem_b[addr_b] <= din_b;
            else       dout_b        <= mem_b[addr_b];
        end
    end

    // Compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit exp_wr;

    initial begin
        rst_a = 1'b1; wv_a = 1'b0; wa_a = '0; wd_a = '0; rv_a = 1'b0; ra_a = '0;
        rst_b = 1'b1; wv_b = 1'b0; wa_b = '0; wd_b = '0; rv_b = 1'b0; ra_b = '0;

        // ---- Reset: requests present but nothing may be granted ----
        tick();
        wv_a = 1'b1; rv_a = 1'b1;
        #2;
        chk("rst_a_ena",  ena_a,  1'b0);
        chk("rst_a_wrdy", wrdy_a, 1'b0);
        chk("rst_a_rrdy", rrdy_a, 1'b0);
        tick();
        rst_a = 1'b0; rst_b = 1'b0; wv_a = 1'b0; rv_a = 1'b0;
        #2;
        chk("rst_a_rspv",  rspv_a, 1'b0);
        chk("rst_a_state", u_a.state_q, IDLE);

        // ---- Write-only: 20 back-to-back writes, MAX_BURST=16 ----
        for (int i = 0; i < 20; i++) begin
            tick();
            wv_a = 1'b1; wa_a = 8'(i); wd_a = 8'(8'h10 + i);
            #2;
            chk($sformatf("wo_wrdy_%0d", i), wrdy_a, 1'b1);
            chk($sformatf("wo_wea_%0d", i),  wea_a,  1'b1);
            chk($sformatf("wo_rrdy_%0d", i), rrdy_a, 1'b0);
            if (i == 16) chk("wo_idle_beat17", u_a.state_q, IDLE);
        end
        tick();
        wv_a = 1'b0;
        #2;
        chk("wo_drop_ena", ena_a, 1'b0);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wo_mem_%0d", i), mem_a[i], 8'(8'h10 + i));

        // ---- Read latency: write A5 to addr 3 then read it ----
        tick();
        wv_a = 1'b1; wa_a = 8'd3; wd_a = 8'hA5;
        #2;
        chk("lat_wr_wrdy", wrdy_a, 1'b1);
        tick();
        wv_a = 1'b0; rv_a = 1'b1; ra_a = 8'd3;
        #2;
        chk("lat_bubble_rrdy", rrdy_a, 1'b0);
        tick();
        #2;
        chk("lat_rd_rrdy", rrdy_a, 1'b1);
        chk("lat_rd_wea",  wea_a,  1'b0);
        chk("lat_rd_rspv", rspv_a, 1'b0);
        tick();
        rv_a = 1'b0;
        #2;
        chk("lat_rspv", rspv_a, 1'b1);
        chk("lat_rspd", rspd_a, 8'hA5);
        tick();
        #2;
        chk("lat_rspv_low", rspv_a, 1'b0);

        // ---- Contention, MAX_BURST=4, both valid for 16 cycles ----
        for (int k = 0; k < 16; k++) begin
            wv_b = 1'b1; wa_b = 8'(8'h40 + k); wd_b = 8'(k); rv_b = 1'b1; ra_b = 8'h40;
            #2;
`ifdef RAM_ARB_RR_EN
            exp_wr = ((k / 4) % 2) == 0;
`else
            exp_wr = 1'b1;
`endif
            chk($sformatf("cont_wrdy_%0d", k), wrdy_b, exp_wr);
            chk($sformatf("cont_rrdy_%0d", k), rrdy_b, !exp_wr);
            chk($sformatf("cont_both_%0d", k), wrdy_b & rrdy_b, 1'b0);
            tick();
        end
        wv_b = 1'b0;
        #2;
        chk("cont_rd_after_drop", rrdy_b, 1'b1);
        tick();
        rv_b = 1'b0;
        #2;
        chk("cont_rspv", rspv_b, 1'b1);
        tick();

        // ---- Bubble: wr_valid drops in beat 3 while rd_valid is high ----
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0; wv_b = 1'b1; rv_b = 1'b1; wa_b = 8'h80; ra_b = 8'h40;
        #2;
        chk("bub_b1_wrdy", wrdy_b, 1'b1);
        tick();
        wa_b = 8'h81;
        #2;
        chk("bub_b2_wrdy", wrdy_b, 1'b1);
        tick();
        wv_b = 1'b0;
        #2;
        chk("bub_b3_ena",  ena_b,  1'b0);
        chk("bub_b3_rrdy", rrdy_b, 1'b0);
        tick();
        #2;
        chk("bub_rd_rrdy", rrdy_b, 1'b1);
        tick();
        rv_b = 1'b0;
        tick();

        // ---- Reset one cycle after a read accept ----
        rv_b = 1'b1; ra_b = 8'h40;
        #2;
        chk("rr_accept_rrdy", rrdy_b, 1'b1);
        tick();
        rst_b = 1'b1; wv_b = 1'b1;
        #2;
        chk("rr_rspv",  rspv_b, 1'b0);
        chk("rr_ena",   ena_b,  1'b0);
        chk("rr_wrdy",  wrdy_b, 1'b0);
        chk("rr_rrdy",  rrdy_b, 1'b0);
        tick();
        rst_b = 1'b0; wv_b = 1'b0; rv_b = 1'b0;
        #2;
        chk("rr_post_rspv",  rspv_b, 1'b0);
        chk("rr_post_state", u_b.state_q, IDLE);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #100000;
        n_err++;
        $display("FAIL timeout: observed no end of run, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule : tb_ram_t0_arbiter

`default_nettype wire

// File: doc/ram_t0_arbiter.md
RAM_T0_ARBITER -- requirements
Module: ram_t0_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default `ADDR_SIZE, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, RAM word width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum consecutive accesses granted to one requester; legal range 1..255.
REQ-004 clka  input  1  single clock; all state updates on its rising edge.
REQ-005 rsta  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  write requester has a beat.
REQ-007 wr_ready  output  1  write beat accepted this cycle.
REQ-008 wr_addr  input  ADDR_SIZE  write address.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 rd_valid  input  1  read requester has a beat.
REQ-011 rd_ready  output  1  read beat accepted this cycle.
REQ-012 rd_addr  input  ADDR_SIZE  read address.
REQ-013 rsp_valid  output  1  read data valid; no backpressure.
REQ-014 rsp_data  output  DATA_WIDTH  read data; equals ram_douta.
REQ-015 ram_ena, ram_wea  output  1 each  RAM enable and write enable.
REQ-016 ram_addra  output  ADDR_SIZE; ram_dina  output  DATA_WIDTH  RAM address and write data.
REQ-017 ram_douta  input  DATA_WIDTH  RAM read data, 1-cycle registered latency.

Function
REQ-018 SHALL issue at most one RAM access per cycle; wr_ready and rd_ready SHALL never both be 1.
REQ-019 SHALL have a registered FSM with states IDLE, WR and RD, plus a beat counter (8 bits) and a last_grant register.
REQ-020 IDLE: arbitrate combinationally and issue the winner's access in the same cycle, then move to the winner's state with beat=1; with neither valid, stay in IDLE with ram_ena=0.
REQ-021 WR: wr_ready = wr_valid; accept drives ram_ena=1, ram_wea=1, ram_addra=wr_addr, ram_dina=wr_data, and increments beat.
REQ-022 RD: rd_ready = rd_valid; accept drives ram_ena=1, ram_wea=0, ram_addra=rd_addr.
REQ-023 In WR or RD, if the granted valid is 0, issue no access that cycle, go to IDLE and set last_grant to the current state.
REQ-024 When an accept brings beat to MAX_BURST, go to IDLE next cycle and set last_grant; MAX_BURST=1 means every access passes through IDLE.
REQ-025 rsp_valid SHALL be 1 exactly one cycle after each accepted read, otherwise 0.
REQ-026 The non-granted requester's ready SHALL be 0. Its request SHALL be held until accepted, and its valid/addr/data SHALL stay stable while waiting.
REQ-027 ram_ena=0 SHALL force ram_wea=0. Address and data outputs are don't-care when ram_ena=0.

Reset
REQ-028 rsta=1 SHALL set state=IDLE, beat=0, last_grant=RD and rsp_valid=0 on the next edge.
REQ-029 While rsta=1, ram_ena, wr_ready and rd_ready SHALL be 0.
REQ-030 Reset mid-burst SHALL abandon the burst. A read accepted in the cycle before reset asserts SHALL NOT produce rsp_valid.

Configuration
REQ-031 Macro RAM_ARB_RR_EN defined: when both requesters are valid in IDLE, grant the one that is not last_grant (round-robin).
REQ-032 RAM_ARB_RR_EN undefined: when both are valid in IDLE, write always wins (fixed priority). MAX_BURST still ends each burst, and last_grant is updated but ignored.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/WR/RD), the grant enum (GNT_WR/GNT_RD) and the default MAX_BURST constant.
REQ-034 No sub-module; the RAM is instantiated outside this block, and the bench connects it to a ram_t0 instance.

Verification
REQ-035 Write-only: 20 back-to-back writes, MAX_BURST=16 -> beats 1-16 accepted consecutively, 1 IDLE cycle with wr_ready=1 re-granting (beat 17), all 20 written to RAM.
REQ-036 Read latency: write 0xA5 to addr 3, then read addr 3 -> rsp_valid high exactly 1 cycle after rd_ready, rsp_data=0xA5.
REQ-037 Contention, RAM_ARB_RR_EN defined, both valid continuously, MAX_BURST=4 -> grants alternate in bursts of 4 (first burst write), never both ready.
REQ-038 Contention, macro undefined, both valid, MAX_BURST=4 -> write always wins each IDLE; read is granted only once wr_valid drops.
REQ-039 Bubble: wr_valid drops in beat 3 of WR while rd_valid=1 -> no access that cycle, IDLE next, read granted.
REQ-040 Reset: assert rsta one cycle after a read accept -> rsp_valid stays 0, state IDLE, ram_ena=0 during reset.
